// File: rtl/gpu_pkg.sv
// gpu_pkg -- definitions shared across the GPU drawing engines.
//   rf_state_t : rect_fill controller states
//   XMAX_DEF / YMAX_DEF : last visible column / row of the default 640x480 raster
//   ENG_* : engine select codes used by the coordinate mux
package gpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_FIN   = 2'd3
  } rf_state_t;

  localparam int XMAX_DEF = 639;
  localparam int YMAX_DEF = 479;

  localparam logic [3:0] ENG_CF   = 4'd0;
  localparam logic [3:0] ENG_CD   = 4'd1;
  localparam logic [3:0] ENG_RF   = 4'd2;
  localparam logic [3:0] ENG_RD   = 4'd3;
  localparam logic [3:0] ENG_LD   = 4'd4;
  localparam logic [3:0] ENG_FU   = 4'd10;
  localparam logic [3:0] ENG_IDLE = 4'd15;

endpackage

// File: rtl/raster_counter.sv
// raster_counter -- nested x/y counter that walks a rectangle row-major.
//   CLK, RST          : clock, asynchronous active-high reset (x=y=0)
//   load              : start a new walk at (xmin, ymin)
//   adv               : step to the next pixel
//   xmin, ymin, xmax, ymax : rectangle bounds (xmin/xmax must stay stable while walking)
//   x, y              : current pixel
//   last              : current pixel is (xmax, ymax)
module raster_counter #(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load,
  input  logic          adv,
  input  logic [XW-1:0] xmin,
  input  logic [YW-1:0] ymin,
  input  logic [XW-1:0] xmax,
  input  logic [YW-1:0] ymax,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  // Row end is detected by equality, so an all-ones xmax never needs x to wrap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= xmin;
      y <= ymin;
    end else if (adv) begin
      if (x == xmax) begin
        x <= xmin;
        y <= y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign last = (x == xmax) && (y == ymax);

endmodule

// File: rtl/rect_fill.sv
// rect_fill -- emits every pixel of an axis-aligned rectangle, row-major,
// over a VALID/READY handshake.
//   CLK, RST        : clock, asynchronous active-high reset
//   START           : one-cycle fill request, sampled only when idle
//   ABORT           : synchronous cancel, returns to idle without DONE
//   X0, X1, Y0, Y1  : rectangle corners in any order
//   COLOR           : fill colour, captured with START
//   READY           : downstream accepts the presented pixel
//   VALID           : xRF/yRF/cOut hold a pixel
//   xRF, yRF, cOut  : pixel coordinate and colour
//   BUSY            : not idle
//   DONE            : one-cycle pulse when a fill completes
// Build option: define RECT_FILL_CLIP_EN to clamp the rectangle to XMAX/YMAX;
// a rectangle lying wholly outside the visible area then completes with no pixels.
module rect_fill
  import gpu_pkg::*;
#(
  parameter int XW   = 10,
  parameter int YW   = 9,
  parameter int XMAX = XMAX_DEF,
  parameter int YMAX = YMAX_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          ABORT,
  input  logic [XW-1:0] X0,
  input  logic [XW-1:0] X1,
  input  logic [YW-1:0] Y0,
  input  logic [YW-1:0] Y1,
  input  logic [7:0]    COLOR,
  input  logic          READY,
  output logic          VALID,
  output logic [XW-1:0] xRF,
  output logic [YW-1:0] yRF,
  output logic [7:0]    cOut,
  output logic          BUSY,
  output logic          DONE
);

`ifdef RECT_FILL_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [XW-1:0] XMAX_W = XW'(XMAX);
  localparam logic [YW-1:0] YMAX_W = YW'(YMAX);

  rf_state_t     state_q, state_d;
  logic [XW-1:0] xmin_q, xmax_q, xmax_eff;
  logic [YW-1:0] ymin_q, ymax_q, ymax_eff;
  logic [7:0]    color_q;
  logic          empty, last, load, adv;

  // Corners are sorted as they are captured so later stages see min/max only.
  // Reset clears them too because cOut must read 0 under reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      color_q <= '0;
    end else if (state_q == ST_IDLE && START) begin
      xmin_q  <= (X0 < X1) ? X0 : X1;
      xmax_q  <= (X0 < X1) ? X1 : X0;
      ymin_q  <= (Y0 < Y1) ? Y0 : Y1;
      ymax_q  <= (Y0 < Y1) ? Y1 : Y0;
      color_q <= COLOR;
    end
  end

  // Clipping is evaluated from the latched bounds, which stay frozen for the
  // whole fill, so the clamped values can feed the counter combinationally.
  assign xmax_eff = (CLIP_EN && xmax_q > XMAX_W) ? XMAX_W : xmax_q;
  assign ymax_eff = (CLIP_EN && ymax_q > YMAX_W) ? YMAX_W : ymax_q;
  assign empty    = CLIP_EN && (xmin_q > XMAX_W || ymin_q > YMAX_W);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (START) state_d = ST_SETUP;
      ST_SETUP: if (ABORT) state_d = ST_IDLE;
                else if (empty) state_d = ST_FIN;
                else state_d = ST_FILL;
      ST_FILL:  if (ABORT) state_d = ST_IDLE;
                else if (READY && last) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ABORT suppresses the step so a cancelled pixel is never counted as sent.
  assign load = (state_q == ST_SETUP);
  assign adv  = (state_q == ST_FILL) && READY && !ABORT;

  raster_counter #(
    .XW (XW),
    .YW (YW)
  ) u_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .load (load),
    .adv  (adv),
    .xmin (xmin_q),
    .ymin (ymin_q),
    .xmax (xmax_eff),
    .ymax (ymax_eff),
    .x    (xRF),
    .y    (yRF),
    .last (last)
  );

  assign cOut  = color_q;
  assign VALID = (state_q == ST_FILL);
  assign BUSY  = (state_q != ST_IDLE);
  assign DONE  = (state_q == ST_FIN);

endmodule

// File: tb/tb_rect_fill.sv
// tb_rect_fill -- randomized self-checking bench for rect_fill.
module tb_rect_fill;

`ifdef RECT_FILL_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST, START, ABORT, READY;
  logic [9:0] X0, X1;
  logic [8:0] Y0, Y1;
  logic [7:0] COLOR;
  logic       VALID, BUSY, DONE;
  logic [9:0] xRF;
  logic [8:0] yRF;
  logic [7:0] cOut;

  int n_tests = 0;
  int n_fail  = 0;

  logic [26:0] got_px[$];
  int          got_cyc[$];
  logic [26:0] exp_px[$];
  int first_vld, done_cyc, done_cnt, hold_err, abort_vld;
  bit timeout;

  rect_fill dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .X0(X0), .X1(X1), .Y0(Y0), .Y1(Y1), .COLOR(COLOR), .READY(READY),
    .VALID(VALID), .xRF(xRF), .yRF(yRF), .cOut(cOut), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: enumerate the rectangle with plain integer loops.
  function automatic void build_exp(input int x0, x1, y0, y1, input logic [7:0] col);
    int xlo, xhi, ylo, yhi;
    exp_px.delete();
    xlo = (x0 < x1) ? x0 : x1;  xhi = (x0 < x1) ? x1 : x0;
    ylo = (y0 < y1) ? y0 : y1;  yhi = (y0 < y1) ? y1 : y0;
    if (CLIP) begin
      if (xhi > 639) xhi = 639;
      if (yhi > 479) yhi = 479;
    end
    for (int y = ylo; y <= yhi; y++)
      for (int x = xlo; x <= xhi; x++)
        exp_px.push_back({10'(x), 9'(y), col});
  endfunction

  // Drives one fill and records what the DUT emits, cycle-indexed from the
  // edge that sampled START. rdy_pct<0 selects the fixed 1,0,0,1 READY pattern.
  task automatic run_fill(input int x0, x1, y0, y1, input logic [7:0] col,
                          input int rdy_pct, input int abort_after, input bit restart);
    int pat[4] = '{1, 0, 0, 1};
    logic [26:0] prev;
    bit hold, ab_pend;
    got_px.delete(); got_cyc.delete();
    first_vld = -1; done_cyc = -1; done_cnt = 0; hold_err = 0; abort_vld = -1;
    timeout = 1; hold = 0; ab_pend = 0; prev = '0;
    X0 = 10'(x0); X1 = 10'(x1); Y0 = 9'(y0); Y1 = 9'(y1); COLOR = col;
    START = 1; ABORT = 0; READY = 1;
    @(posedge CLK); #1;
    START = 0;
    for (int c = 1; c < 4000; c++) begin
      if (ab_pend) begin abort_vld = int'(VALID); ab_pend = 0; end
      if (VALID && first_vld < 0) first_vld = c;
      if (DONE) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (hold && {xRF, yRF, cOut} !== prev) hold_err++;
      if (!BUSY) begin timeout = 0; break; end
      START = 0; ABORT = 0;
      if (rdy_pct < 0) READY = (c >= 2 && c <= 5) ? (pat[c-2] != 0) : 1'b1;
      else             READY = ($urandom_range(0, 99) < rdy_pct);
      if (restart && c == 3) begin
        START = 1; X0 = 10'($urandom); X1 = 10'($urandom);
        Y0 = 9'($urandom); Y1 = 9'($urandom); COLOR = ~col;
      end
      if (abort_after >= 0 && VALID && got_px.size() == abort_after) begin
        ABORT = 1; ab_pend = 1;
      end
      if (VALID && READY && !ABORT) begin
        got_px.push_back({xRF, yRF, cOut});
        got_cyc.push_back(c);
      end
      hold = VALID && !READY && !ABORT;
      prev = {xRF, yRF, cOut};
      @(posedge CLK); #1;
    end
    START = 0; ABORT = 0; READY = 1;
  endtask

  task automatic test_reset();
    RST = 1; START = 0; ABORT = 0; READY = 1;
    X0 = 0; X1 = 0; Y0 = 0; Y1 = 0; COLOR = 0;
    repeat (3) @(posedge CLK);
    #1;
    n_tests++;
    if ({VALID, BUSY, DONE} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: VALID/BUSY/DONE=%b want 000", {VALID, BUSY, DONE});
    end
    n_tests++;
    if ({xRF, yRF, cOut} !== 27'd0) begin
      n_fail++; $display("FAIL reset_data: x=%0d y=%0d c=%0d want 0", xRF, yRF, cOut);
    end
    RST = 0;
    @(posedge CLK); #1;
    n_tests++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: BUSY=%b want 0", BUSY); end
  endtask

  task automatic test_basic();
    int xs[6] = '{10, 11, 12, 10, 11, 12};
    int ys[6] = '{5, 5, 5, 6, 6, 6};
    run_fill(10, 12, 5, 6, 8'hA5, 100, -1, 0);
    n_tests++;
    if (timeout || got_px.size() != 6) begin
      n_fail++; $display("FAIL basic_count: got %0d pixels (timeout=%0d) want 6", got_px.size(), timeout);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_tests++;
        if (got_px[i] !== {10'(xs[i]), 9'(ys[i]), 8'hA5} || got_cyc[i] != 2 + i) begin
          n_fail++;
          $display("FAIL basic_px%0d: got (%0d,%0d,c%0h)@%0d want (%0d,%0d,ca5)@%0d", i,
                   got_px[i][26:17], got_px[i][16:8], got_px[i][7:0], got_cyc[i], xs[i], ys[i], 2 + i);
        end
      end
    end
    n_tests++;
    if (first_vld != 2) begin n_fail++; $display("FAIL basic_latency: first VALID cycle %0d want 2", first_vld); end
    n_tests++;
    if (done_cnt != 1 || done_cyc != 8) begin
      n_fail++; $display("FAIL basic_done: %0d pulses at cycle %0d want 1 at 8", done_cnt, done_cyc);
    end
  endtask

  // Shared by several scenarios: full model comparison of the last run.
  task automatic test_model_case(input string name, input int x0, x1, y0, y1,
                                 input int rdy_pct, input bit restart);
    logic [7:0] col;
    col = 8'($urandom);
    build_exp(x0, x1, y0, y1, col);
    run_fill(x0, x1, y0, y1, col, rdy_pct, -1, restart);
    n_tests++;
    if (timeout || got_px.size() != exp_px.size()) begin
      n_fail++; $display("FAIL %s_count: got %0d pixels (timeout=%0d) want %0d", name, got_px.size(), timeout, exp_px.size());
    end else begin
      for (int i = 0; i < exp_px.size(); i++) begin
        if (got_px[i] !== exp_px[i]) begin
          n_fail++; $display("FAIL %s_px%0d: got %h want %h", name, i, got_px[i], exp_px[i]);
          break;
        end
      end
    end
    n_tests++;
    if (done_cnt != 1 || (exp_px.size() > 0 && done_cyc != got_cyc[got_cyc.size()-1] + 1)) begin
      n_fail++; $display("FAIL %s_done: %0d pulses at cycle %0d", name, done_cnt, done_cyc);
    end
    n_tests++;
    if (hold_err != 0) begin n_fail++; $display("FAIL %s_hold: %0d changes while stalled want 0", name, hold_err); end
    if (rdy_pct == 100 && exp_px.size() > 0) begin
      n_tests++;
      if (first_vld != 2 || got_cyc[got_cyc.size()-1] != 1 + exp_px.size()) begin
        n_fail++; $display("FAIL %s_nobubble: first %0d last %0d want 2 and %0d", name,
                           first_vld, got_cyc[got_cyc.size()-1], 1 + exp_px.size());
      end
    end
  endtask

  task automatic test_abort();
    build_exp(20, 23, 30, 33, 8'h11);
    run_fill(20, 23, 30, 33, 8'h11, 100, 2, 0);
    n_tests++;
    if (timeout || got_px.size() != 2 || got_px[0] !== exp_px[0] || got_px[1] !== exp_px[1]) begin
      n_fail++; $display("FAIL abort_pixels: got %0d pixels (timeout=%0d) want 2 matching", got_px.size(), timeout);
    end
    n_tests++;
    if (abort_vld != 0 || done_cnt != 0) begin
      n_fail++; $display("FAIL abort_state: VALID after abort=%0d DONE pulses=%0d want 0 and 0", abort_vld, done_cnt);
    end
  endtask

  task automatic test_reset_midfill();
    X0 = 0; X1 = 3; Y0 = 0; Y1 = 3; COLOR = 8'h3C; READY = 1; START = 1;
    @(posedge CLK); #1;
    START = 0;
    repeat (4) @(posedge CLK);
    #1;
    n_tests++;
    if (VALID !== 1'b1) begin n_fail++; $display("FAIL midfill_pre: VALID=%b want 1", VALID); end
    #2 RST = 1;
    #1;
    n_tests++;
    if ({VALID, BUSY, DONE, xRF, yRF, cOut} !== 30'd0) begin
      n_fail++; $display("FAIL midfill_async_reset: V=%b B=%b D=%b x=%0d y=%0d c=%0d want all 0",
                         VALID, BUSY, DONE, xRF, yRF, cOut);
    end
    @(posedge CLK); #1;
    RST = 0;
    build_exp(1, 2, 1, 1, 8'h77);
    run_fill(1, 2, 1, 1, 8'h77, 100, -1, 0);
    n_tests++;
    if (timeout || first_vld != 2 || got_px.size() != 2 || got_px[0] !== exp_px[0]) begin
      n_fail++; $display("FAIL start_after_reset: first VALID %0d, %0d pixels want 2, 2", first_vld, got_px.size());
    end
  endtask

  task automatic test_clip();
    run_fill(636, 645, 478, 478, 8'h5A, 100, -1, 0);
    n_tests++;
    if (got_px.size() != (CLIP ? 4 : 10) || got_px[got_px.size()-1][26:17] != (CLIP ? 10'd639 : 10'd645)) begin
      n_fail++; $display("FAIL clip_span: got %0d pixels want %0d", got_px.size(), CLIP ? 4 : 10);
    end
    run_fill(700, 710, 478, 478, 8'h5A, 100, -1, 0);
    n_tests++;
    if (timeout || got_px.size() != (CLIP ? 0 : 11) || done_cnt != 1) begin
      n_fail++; $display("FAIL clip_outside: got %0d pixels, %0d DONE want %0d and 1",
                         got_px.size(), done_cnt, CLIP ? 0 : 11);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      int x0, y0;
      x0 = $urandom_range(0, 1015);
      y0 = $urandom_range(0, 505);
      test_model_case("random", x0, x0 + $urandom_range(0, 7), y0 + $urandom_range(0, 5), y0,
                      (k % 2) ? 100 : 60, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_model_case("swap", 12, 10, 6, 5, 100, 0);
    test_model_case("point", 7, 7, 3, 3, 100, 0);
    test_model_case("stall", 40, 41, 50, 51, -1, 0);
    test_model_case("restart", 100, 104, 200, 202, 100, 1);
    test_model_case("edge_ones", 1021, 1023, 510, 511, 70, 0);
    test_abort();
    test_reset_midfill();
    test_clip();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rect_fill.md
RECT_FILL -- requirements
Module: rect_fill

Interface
REQ-001 Parameter XW, default 10, sets the x coordinate width in bits.
REQ-002 Parameter YW, default 9, sets the y coordinate width in bits.
REQ-003 Parameter XMAX, default 639, is the last visible column.
REQ-004 Parameter YMAX, default 479, is the last visible row.
REQ-005 CLK  in  1  is the single clock; all state changes on its rising edge.
REQ-006 RST  in  1  is the reset: asynchronous, active-high.
REQ-007 START  in  1  is a one-cycle request to fill a rectangle; it is sampled only in IDLE.
REQ-008 ABORT  in  1  is a synchronous cancel of the current fill.
REQ-009 X0, X1  in  XW  are corner x coordinates, in any order.
REQ-010 Y0, Y1  in  YW  are corner y coordinates, in any order.
REQ-011 COLOR  in  8  is the fill colour, latched at START.
REQ-012 READY  in  1  means the downstream coordinate mux/framebuffer accepts the pixel this cycle.
REQ-013 VALID  out  1  means xRF/yRF/cOut hold a pixel to be written.
REQ-014 xRF  out  XW, yRF  out  YW, cOut  out  8  are the current pixel x, y and colour.
REQ-015 BUSY  out  1  is high in every state other than IDLE.
REQ-016 DONE  out  1  is a one-cycle pulse when a fill completes.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP, FILL and FIN.
- IDLE -> SETUP on START.
- SETUP -> FILL (or FIN if zero pixels).
- FILL -> FIN after the last transfer.
- FIN -> IDLE unconditionally.
REQ-018 SETUP SHALL latch xmin=min(X0,X1), xmax=max(X0,X1), ymin=min(Y0,Y1), ymax=max(Y0,Y1) and COLOR, all captured in the START cycle.
REQ-019 With START asserted at edge n, VALID SHALL first be high after edge n+2, with xRF=xmin and yRF=ymin.
REQ-020 A transfer occurs when VALID&&READY; pixels SHALL be emitted row-major: x increments to xmax, then x returns to xmin and y increments.
REQ-021 While VALID&&!READY, xRF, yRF and cOut SHALL hold stable.
REQ-022 Within FILL, VALID SHALL stay high with no bubbles, giving one pixel per cycle when READY stays high.
REQ-023 The pixel count SHALL equal (xmax-xmin+1)*(ymax-ymin+1); a degenerate point or line SHALL emit exactly 1 pixel, or the span length.
REQ-024 The transfer of (xmax,ymax) SHALL move the FSM to FIN; VALID SHALL be 0 in FIN and DONE SHALL be 1 for exactly that cycle.
REQ-025 START while BUSY SHALL be ignored and SHALL not alter the latched rectangle.
REQ-026 ABORT in any non-IDLE state SHALL return the FSM to IDLE on the next edge with VALID=0 and no DONE pulse; ABORT has priority over the transfer in the same cycle.
REQ-027 Counter arithmetic SHALL be unsigned at the native XW/YW widths; the row compare SHALL use equality with xmax/ymax, so xmax at its all-ones value SHALL not wrap.

Reset
REQ-028 RST high SHALL immediately force IDLE, VALID=0, BUSY=0, DONE=0, xRF=0, yRF=0 and cOut=0, including mid-fill.
REQ-029 After RST deasserts, the block SHALL accept START on the first following edge.

Configuration
REQ-030 With RECT_FILL_CLIP_EN defined, SETUP SHALL clamp xmax to XMAX and ymax to YMAX; a rectangle with xmin>XMAX or ymin>YMAX SHALL go SETUP->FIN, emitting zero pixels and pulsing DONE.
REQ-031 Without RECT_FILL_CLIP_EN, no clamping SHALL occur and coordinates SHALL pass through over their full XW/YW range.

Structure
REQ-032 The state encoding, the XMAX/YMAX defaults and the engine select codes (CF=0, CD=1, RF=2, RD=3, LD=4, FU=10, IDLE=15) SHALL reside in the shared package gpu_pkg.
REQ-033 The nested x/y raster counter with load, advance and last-pixel flag SHALL be the sub-module raster_counter.

Verification
REQ-034 X0=10,X1=12,Y0=5,Y1=6, READY=1 -> 6 pixels (10,5)(11,5)(12,5)(10,6)(11,6)(12,6) on consecutive cycles, first VALID 2 cycles after START, DONE one cycle after the last pixel.
REQ-035 X0=12,X1=10,Y0=6,Y1=5 -> same sequence as REQ-034 (corner swap).
REQ-036 X0=X1=7, Y0=Y1=3 -> exactly 1 pixel (7,3) then DONE; READY toggling 1,0,0,1 during a 2x2 fill -> outputs held while READY=0, 4 pixels total, no duplicates.
REQ-037 ABORT after the 2nd pixel of a 4x4 fill -> VALID=0 next cycle, no DONE; RST asserted mid-fill -> all outputs 0 asynchronously.
REQ-038 With RECT_FILL_CLIP_EN: X0=636,X1=645,Y0=478,Y1=478 -> 4 pixels x=636..639; X0=700,X1=710 -> 0 pixels and DONE pulse. Without the macro: 10 pixels x=636..645.
REQ-039 START pulsed during FILL with different coordinates -> ignored; original pixel sequence unchanged.
